// File: rtl/pattern_pkg.sv
// Shared types and defaults for the 101 pattern transmitter/detector pair.
package pattern_pkg;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned DEF_GAP   = 1;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter that saturates at zero and exposes a registered zero flag.
module tx_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;
  logic         r_zero;

  // Load takes priority over decrement; the flag tracks the value being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_zero <= (i_load_val == '0);
    end else if (i_dec && !r_zero) begin
      r_cnt  <= r_cnt - W'(1);
      r_zero <= (r_cnt == W'(1));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit word MSB-first,
// repeated a programmable number of times with an optional idle gap.
module serial_pattern_tx
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [CNT_W-1:0] pat_reps,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W   = cnt_width(WIDTH - 1);
  localparam int unsigned GAP_W   = cnt_width((GAP > 0) ? GAP - 1 : 0);
  localparam bit          HAS_GAP = (GAP > 0);
  localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = HAS_GAP ? GAP_W'(GAP - 1) : '0;

  tx_state_t        r_state;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_shift;
  logic             r_x_out;
  logic             r_x_valid;
  logic             r_done;

  logic             w_accept;
  logic             w_shift_go;
  logic             w_gap_go;
  logic             w_idx_zero;
  logic             w_gap_zero;
  logic             w_rep_zero;
  logic             w_word_end;
  logic             w_more_reps;
  logic             w_rep_start;
  logic             w_idx_load;
  logic             w_idx_dec;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic             w_rep_load;
  logic             w_rep_dec;
  logic [CNT_W-1:0] w_rep_load_val;

  // Counter control decoded from the current state; abort freezes all counters.
  assign w_accept       = (r_state == TX_IDLE) && pat_valid && !abort;
  assign w_shift_go     = (r_state == TX_SHIFT) && !abort;
  assign w_gap_go       = (r_state == TX_GAP) && !abort;
  assign w_word_end     = w_shift_go && w_idx_zero;
  assign w_more_reps    = !w_rep_zero;
  assign w_rep_start    = (w_word_end && w_more_reps && !HAS_GAP) || (w_gap_go && w_gap_zero);
  assign w_idx_load     = w_accept || w_rep_start;
  assign w_idx_dec      = w_shift_go && !w_idx_zero;
  assign w_gap_load     = w_word_end && w_more_reps && HAS_GAP;
  assign w_gap_dec      = w_gap_go && !w_gap_zero;
  assign w_rep_load     = w_accept;
  assign w_rep_dec      = w_word_end && w_more_reps;
  // Repetition counter holds the repetitions still to come after the current one.
  assign w_rep_load_val = (pat_reps == '0) ? '0 : pat_reps - CNT_W'(1);

  tx_down_counter #(.W(IDX_W)) u_idx_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_idx_load),
    .i_load_val (IDX_LOAD),
    .i_dec      (w_idx_dec),
    .o_zero     (w_idx_zero)
  );

  tx_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  tx_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_rep_load),
    .i_load_val (w_rep_load_val),
    .i_dec      (w_rep_dec),
    .o_zero     (w_rep_zero)
  );

  // State machine with the shift register and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_pat     <= '0;
      r_shift   <= '0;
      r_x_out   <= 1'b0;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          r_x_out   <= 1'b0;
          r_x_valid <= 1'b0;
          if (w_accept) begin
            r_pat     <= pat_data;
            r_shift   <= {pat_data[WIDTH-2:0], 1'b0};
            r_x_out   <= pat_data[WIDTH-1];
            r_x_valid <= 1'b1;
            r_state   <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (abort) begin
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_state   <= TX_IDLE;
          end else if (!w_idx_zero) begin
            r_x_out   <= r_shift[WIDTH-1];
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_x_valid <= 1'b1;
          end else if (w_more_reps) begin
            if (HAS_GAP) begin
              r_x_out   <= 1'b0;
              r_x_valid <= 1'b0;
              r_state   <= TX_GAP;
            end else begin
              r_x_out   <= r_pat[WIDTH-1];
              r_shift   <= {r_pat[WIDTH-2:0], 1'b0};
              r_x_valid <= 1'b1;
            end
          end else begin
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= TX_IDLE;
          end
        end
        TX_GAP: begin
          if (abort) begin
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_state   <= TX_IDLE;
          end else if (w_gap_zero) begin
            r_x_out   <= r_pat[WIDTH-1];
            r_shift   <= {r_pat[WIDTH-2:0], 1'b0};
            r_x_valid <= 1'b1;
            r_state   <= TX_SHIFT;
          end else begin
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
          end
        end
        default: begin
          r_x_out   <= 1'b0;
          r_x_valid <= 1'b0;
          r_state   <= TX_IDLE;
        end
      endcase
    end
  end

  assign x_out     = r_x_out;
  assign x_valid   = r_x_valid;
  assign done      = r_done;
  assign pat_ready = (r_state == TX_IDLE);
  assign busy      = (r_state != TX_IDLE);

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

- Serial pattern transmitter: accepts a WIDTH-bit pattern word over a valid/ready handshake and emits it MSB-first, one bit per clock, on a serial line.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Transmit-side counterpart of the 101 pattern detector; it drives that detector's `x` input in loopback and in stimulus generation.

## Interface
- `WIDTH`, 3: pattern length in bits (≥2).
- `CNT_W`, 8: width of the repetition count.
- `GAP`, 1: idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pat_data`  in  WIDTH  pattern to send, MSB first.
- `pat_reps`  in  CNT_W  repetition count; 0 is treated as 1.
- `pat_valid`  in  1  request valid.
- `pat_ready`  out  1  block idle, request may be accepted.
- `abort`  in  1  synchronous cancel of the current job.
- `x_out`  out  1  serial data bit.
- `x_valid`  out  1  `x_out` carries a pattern bit this cycle.
- `busy`  out  1  job in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after the last bit of a job.

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE:**
  - `pat_ready`=1.
  - On `pat_valid && pat_ready && !abort` at edge k: latch `pat_data` and `max(pat_reps,1)`, load bit index W-1, go to SHIFT.
- **SHIFT:**
  - `x_out` = latched bit[index], `x_valid`=1; index decrements each cycle.
  - After bit 0: if repetitions remain and GAP>0, go to GAP.
  - If repetitions remain and GAP=0, reload index W-1 and stay in SHIFT.
  - Otherwise go to IDLE and pulse `done`.
- **GAP:**
  - `x_out`=0, `x_valid`=0 for exactly GAP cycles.
  - Then reload index W-1 and go to SHIFT.
- **abort:**
  - Sampled in SHIFT or GAP: next state IDLE, `x_valid`=0, no `done` pulse, latched job discarded.
  - In IDLE, `abort` blocks acceptance in that cycle.
- `pat_data` and `pat_reps` are ignored except at acceptance; changes mid-job have no effect.
- Repetition counter counts down from the latched value, with no wrap. The maximum is 2^CNT_W−1 repetitions.
- Total `x_valid` cycles per completed job = WIDTH × reps.

## Timing
- **Reset values:** state IDLE; `x_out`=0, `x_valid`=0, `busy`=0, `done`=0, `pat_ready`=1.
- **Outputs:** `x_out`, `x_valid` and `done` are registered. `pat_ready`=(state==IDLE) and `busy` are decoded from the state register.
- **Latency:** accept at edge k, so the first bit (MSB) appears after edge k, i.e. in cycle k+1. Bit j of repetition r (0-based, j from MSB) appears in cycle k+1 + r·(WIDTH+GAP) + j.
- **Completion:**
  - The last bit appears in cycle k + reps·WIDTH + (reps−1)·GAP.
  - `done`=1 and `pat_ready`=1 in the following cycle.
  - A new request is accepted at the end of that cycle, giving a minimum of one idle cycle between jobs.
- **Mid-operation events:**
  - Async reset mid-job: outputs return to reset values immediately. No `done`, no partial resume.
  - `abort` on the cycle the last bit is shown: the job is treated as aborted and `done` stays 0.

## Structure
- Shared package `pattern_pkg`:
  - `tx_state_t` enum {IDLE, SHIFT, GAP}.
  - Default `WIDTH`/`GAP` constants, shared with the 101 detector's package entries.
- One sub-module, `tx_down_counter`: a loadable down-counter with a zero flag. It is instantiated three times, for bit index, gap count and repetition count.
- Shift/output register and FSM stay in the top module.

## Test plan
- **Single job:** reset, then WIDTH=3, `pat_data`=3'b101, reps=1 → `x_out` 1,0,1 with `x_valid`=1 in cycles k+1..k+3. `done`=1 in cycle k+4 only.
- **Repeats with gap:** reps=3, GAP=1 → valid bits 101_0_101_0_101, 9 `x_valid` cycles, `done` at k+12. Loopback into the 101 pattern detector gives 3 `y` pulses.
- **reps=0:** behaves exactly as reps=1. With GAP=0 and reps=2, bits 101101 appear back-to-back and `done` is at k+7.
- **Handshake:** `pat_valid` held high continuously → jobs accepted one cycle after each `done`. `pat_data` changed mid-job does not alter output; `pat_ready`=0 while `busy`.
- **Abort:** `abort` in the 2nd bit of rep 2 → `x_valid`=0 next cycle, no `done`, `pat_ready`=1. A simultaneous `pat_valid`+`abort` in IDLE is not accepted.
- **Reset mid-job:** `rst_n` low during GAP → all outputs at reset values asynchronously. A job after release starts cleanly with the MSB.
